// File: rtl/mask_sched_pkg.sv
// Shared types and constants for the four-lane mask scheduler.
// No logic; lane count, state encoding and default threshold only.
// Imported by the scheduler top and its lane FIFO wrapper.
package mask_sched_pkg;
  localparam int N_LANES = 4;
  localparam logic [7:0] THR_DEFAULT = 8'd50;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [$clog2(N_LANES)-1:0] lane_idx_t;
endpackage

// File: rtl/mask_lane_fifo.sv
// 1-bit synchronous FIFO holding returned masks for one lane.
// Latency: write visible at head one cycle later; head is a plain register read.
// Backpressure: writes while full and reads while empty are ignored; caller gates both.
module mask_lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic wr_vld,
  input  logic wr_dat,
  input  logic rd_rdy,
  output logic rd_dat,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign empty  = (cnt == '0);
  assign full   = (cnt == DEPTH_C);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign rd_dat = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wr_dat;
        wptr      <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
      if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
      else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/mask_lane_sched.sv
// Round-robin pixel dispatch to four mask lanes with in-order mask re-serialisation.
// Latency: pixel to lane one cycle; lane mask to o_MASK one cycle when at head.
// Backpressure: o_DATA_READY drops while the target lane holds LANE_DEPTH in-flight pixels.
module mask_lane_sched
  import mask_sched_pkg::*;
#(
  parameter int         DATA_WIDTH  = 24,
  parameter int         IMG_PIXELS  = 76800,
  parameter int         LANE_DEPTH  = 4,
  parameter logic [7:0] THR_DEFAULT = mask_sched_pkg::THR_DEFAULT
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_FRAME_START,
  input  logic [7:0]            i_THRESHOLD,
  input  logic                  i_THR_LOAD,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_DATA_VALID,
  output logic                  o_DATA_READY,
  output logic [DATA_WIDTH-1:0] o_LANE_DATA [0:N_LANES-1],
  output logic                  o_LANE_VALID [0:N_LANES-1],
  output logic [7:0]            o_LANE_THRESHOLD,
  input  logic                  i_LANE_MASK [0:N_LANES-1],
  input  logic                  i_LANE_MASK_VALID [0:N_LANES-1],
  output logic                  o_MASK,
  output logic                  o_MASK_VALID,
  output logic                  o_FRAME_DONE,
  output logic                  o_BUSY,
  output logic                  o_ERR
);
  localparam int CNT_W = $clog2(IMG_PIXELS + 1);
  localparam int CRD_W = $clog2(LANE_DEPTH + 1);
  localparam logic [CNT_W-1:0] IMG_C   = CNT_W'(IMG_PIXELS);
  localparam logic [CNT_W-1:0] IMG_M1  = CNT_W'(IMG_PIXELS - 1);
  localparam logic [CRD_W-1:0] DEPTH_C = CRD_W'(LANE_DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [CRD_W-1:0]   credit [N_LANES];
  lane_idx_t          dispatch_ptr;
  lane_idx_t          collect_ptr;

  logic               accept;
  logic               head_vld;
  logic               head_dat;
  logic [N_LANES-1:0] lane_ok;
  logic [N_LANES-1:0] lane_err;
  logic [N_LANES-1:0] dsp;
  logic [N_LANES-1:0] col;
  logic [N_LANES-1:0] fifo_wr;
  logic [N_LANES-1:0] fifo_rd;
  logic [N_LANES-1:0] fifo_full;
  logic [N_LANES-1:0] fifo_empty;
  logic [N_LANES-1:0] fifo_dat;

  assign o_DATA_READY = (state == RUN) && (credit[dispatch_ptr] < DEPTH_C);
  assign accept       = i_DATA_VALID && o_DATA_READY;

  // A mask arriving at an empty head lane bypasses its FIFO so it leaves next cycle.
  always_comb begin
    for (int n = 0; n < N_LANES; n++) begin
      lane_ok[n]  = i_LANE_MASK_VALID[n] && (state != IDLE) && !fifo_full[n] && (credit[n] != '0);
      lane_err[n] = i_LANE_MASK_VALID[n] && !lane_ok[n];
      dsp[n]      = accept && (dispatch_ptr == lane_idx_t'(n));
    end
    head_vld = !fifo_empty[collect_ptr] || lane_ok[collect_ptr];
    head_dat = fifo_empty[collect_ptr] ? i_LANE_MASK[collect_ptr] : fifo_dat[collect_ptr];
    for (int n = 0; n < N_LANES; n++) begin
      col[n]     = head_vld && (collect_ptr == lane_idx_t'(n));
      fifo_rd[n] = col[n] && !fifo_empty[n];
      fifo_wr[n] = lane_ok[n] && !(col[n] && fifo_empty[n]);
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    mask_lane_fifo #(.DEPTH(LANE_DEPTH)) u_fifo (
      .core_clk (i_CLK),
      .arst_n   (i_RSTn),
      .wr_vld   (fifo_wr[g]),
      .wr_dat   (i_LANE_MASK[g]),
      .rd_rdy   (fifo_rd[g]),
      .rd_dat   (fifo_dat[g]),
      .full     (fifo_full[g]),
      .empty    (fifo_empty[g])
    );
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state            <= IDLE;
      in_cnt           <= '0;
      out_cnt          <= '0;
      dispatch_ptr     <= '0;
      collect_ptr      <= '0;
      o_LANE_THRESHOLD <= THR_DEFAULT;
      o_MASK           <= 1'b0;
      o_MASK_VALID     <= 1'b0;
      o_FRAME_DONE     <= 1'b0;
      o_BUSY           <= 1'b0;
      o_ERR            <= 1'b0;
      for (int n = 0; n < N_LANES; n++) begin
        credit[n]       <= '0;
        o_LANE_DATA[n]  <= '0;
        o_LANE_VALID[n] <= 1'b0;
      end
    end else begin
      for (int n = 0; n < N_LANES; n++) begin
        o_LANE_VALID[n] <= dsp[n];
        if (dsp[n]) o_LANE_DATA[n] <= i_DATA;
        if (dsp[n] && !col[n])      credit[n] <= credit[n] + 1'b1;
        else if (!dsp[n] && col[n]) credit[n] <= credit[n] - 1'b1;
      end

      if (accept) begin
        in_cnt       <= in_cnt + 1'b1;
        dispatch_ptr <= dispatch_ptr + 1'b1;
      end

      o_MASK_VALID <= head_vld;
      if (head_vld) begin
        o_MASK      <= head_dat;
        out_cnt     <= out_cnt + 1'b1;
        collect_ptr <= collect_ptr + 1'b1;
      end

      o_BUSY       <= (state == RUN) || (state == DRAIN);
      o_FRAME_DONE <= (state == DONE);

      case (state)
        IDLE: begin
          if (i_THR_LOAD) o_LANE_THRESHOLD <= i_THRESHOLD;
          if (i_FRAME_START) begin
            in_cnt       <= '0;
            out_cnt      <= '0;
            dispatch_ptr <= '0;
            collect_ptr  <= '0;
            o_ERR        <= 1'b0;
            state        <= RUN;
          end
        end
        RUN:     if (accept && (in_cnt == IMG_M1)) state <= DRAIN;
        DRAIN:   if (out_cnt == IMG_C) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Protocol errors win over the clear from a same-cycle frame start.
      if (|lane_err) o_ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mask_lane_sched.sv
// Randomized scoreboard bench for mask_lane_sched with behavioural lane models.
// Expected masks are pixel LSBs in acceptance order; readiness follows per-lane in-flight counts.
module tb_mask_lane_sched;
  localparam int DW   = 24;
  localparam int NPIX = 22;
  localparam int LD   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [7:0]    thr = 8'd0;
  logic          thr_load = 1'b0;
  logic [DW-1:0] data = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [DW-1:0] lane_data [0:3];
  logic          lane_valid [0:3];
  logic [7:0]    lane_thr;
  logic          lane_mask [0:3];
  logic          lane_mask_valid [0:3];
  logic          mask, mask_valid, frame_done, busy, err;

  mask_lane_sched #(
    .DATA_WIDTH (DW),
    .IMG_PIXELS (NPIX),
    .LANE_DEPTH (LD)
  ) dut (
    .i_CLK             (clk),
    .i_RSTn            (rst_n),
    .i_FRAME_START     (frame_start),
    .i_THRESHOLD       (thr),
    .i_THR_LOAD        (thr_load),
    .i_DATA            (data),
    .i_DATA_VALID      (data_valid),
    .o_DATA_READY      (data_ready),
    .o_LANE_DATA       (lane_data),
    .o_LANE_VALID      (lane_valid),
    .o_LANE_THRESHOLD  (lane_thr),
    .i_LANE_MASK       (lane_mask),
    .i_LANE_MASK_VALID (lane_mask_valid),
    .o_MASK            (mask),
    .o_MASK_VALID      (mask_valid),
    .o_FRAME_DONE      (frame_done),
    .o_BUSY            (busy),
    .o_ERR             (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lane models: each lane returns mask = pixel LSB, in order, lat[n] cycles after its input.
  int lat [4];
  int lane_q [4][$];
  initial begin
    for (int n = 0; n < 4; n++) begin
      lane_mask_valid[n] = 1'b0;
      lane_mask[n]       = 1'b0;
      lat[n]             = 3;
    end
    forever begin
      @(posedge clk); #1;
      for (int n = 0; n < 4; n++) begin
        lane_mask_valid[n] = 1'b0;
        lane_mask[n]       = 1'b0;
        if (rst_n && lane_valid[n])
          lane_q[n].push_back((cyc + lat[n]) * 2 + int'(lane_data[n][0]));
        if (lane_q[n].size() > 0 && (lane_q[n][0] / 2) <= cyc) begin
          lane_mask_valid[n] = 1'b1;
          lane_mask[n]       = (lane_q[n][0] % 2) != 0;
          void'(lane_q[n].pop_front());
        end
      end
    end
  end

  // Scoreboard monitor.
  logic exp_q [$];
  int   acc_lane [4];
  int   out_lane [4];
  int   acc_total = 0;
  int   out_total = 0;
  int   last_mask_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mask_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mask_unexpected: got o_MASK_VALID=1, expected no output (cycle %0d)", cyc);
        end else begin
          check("mask_order", 32'(mask), 32'(exp_q.pop_front()));
        end
        out_lane[out_total % 4]++;
        out_total++;
        last_mask_cyc = cyc;
      end
      if (rst_n && frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_reset(input string tag);
    int s;
    s = 0;
    for (int n = 0; n < 4; n++) s += int'(lane_valid[n]);
    check({tag, "_ready"}, 32'(data_ready), 0);
    check({tag, "_mask_valid"}, 32'(mask_valid), 0);
    check({tag, "_mask"}, 32'(mask), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_lane_valid"}, 32'(s), 0);
    check({tag, "_threshold"}, 32'(lane_thr), 50);
  endtask

  task automatic run_frame(input int pct, input bit disturb);
    int guard, l, s, done_base;
    bit acc, disturbed;
    logic [DW-1:0] pix;
    acc_total = 0;
    out_total = 0;
    for (int n = 0; n < 4; n++) begin
      acc_lane[n] = 0;
      out_lane[n] = 0;
    end
    done_base = done_cnt;
    disturbed = 1'b0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    check("err_clear_on_start", 32'(err), 0);
    guard = 0;
    while (acc_total < NPIX && guard < 1000) begin
      data_valid = ($urandom_range(99) < pct);
      data       = DW'($urandom);
      if (disturb && !disturbed && acc_total == 3) begin
        frame_start = 1'b1;
        thr         = 8'd20;
        thr_load    = 1'b1;
        disturbed   = 1'b1;
      end
      @(negedge clk); #1;
      if (guard == 0) check("busy_delayed", 32'(busy), 0);
      if (guard == 1) check("busy_run", 32'(busy), 1);
      l = acc_total % 4;
      check("ready", 32'(data_ready), 32'((acc_lane[l] - out_lane[l]) < LD));
      acc = data_valid && data_ready;
      pix = data;
      if (acc) begin
        exp_q.push_back(data[0]);
        acc_lane[l]++;
        acc_total++;
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
      thr_load    = 1'b0;
      if (acc) begin
        s = 0;
        for (int n = 0; n < 4; n++) s += int'(lane_valid[n]);
        check("lane_valid", 32'(lane_valid[l]), 1);
        check("lane_valid_onehot", 32'(s), 1);
        check("lane_data", 32'(lane_data[l]), 32'(pix));
      end
      guard++;
    end
    data_valid = 1'b0;
    if (acc_total < NPIX) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d pixels accepted, expected %0d", acc_total, NPIX);
    end
    @(negedge clk); #1;
    check("ready_drain", 32'(data_ready), 0);
    guard = 0;
    while (done_cnt == done_base && guard < 600) begin
      @(negedge clk); #1;
      guard++;
    end
    if (done_cnt == done_base) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no o_FRAME_DONE, expected one after %0d masks", NPIX);
    end else begin
      check("done_latency", 32'(done_cyc), 32'(last_mask_cyc + 2));
      check("busy_after_done", 32'(busy), 0);
    end
    check("mask_count", 32'(out_total), NPIX);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    check("err_frame", 32'(err), 0);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(frame_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected the bench to finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Threshold load in IDLE.
    @(posedge clk); #1 thr = 8'd80; thr_load = 1'b1;
    @(posedge clk); #1 thr_load = 1'b0;
    check("thr_load_idle", 32'(lane_thr), 80);

    // Continuous stream, fixed latency; a frame start and a threshold load land mid-RUN.
    run_frame(100, 1'b1);
    check("thr_locked_in_run", 32'(lane_thr), 80);

    // Slow lane 2 fills its credits and stalls input.
    lat[0] = 2; lat[1] = 3; lat[2] = 10; lat[3] = 1;
    run_frame(100, 1'b0);

    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 4; n++) lat[n] = $urandom_range(6, 1);
      run_frame(60, 1'b0);
    end

    // Spurious mask with no credit while IDLE.
    @(posedge clk); #2 lane_mask_valid[1] = 1'b1; lane_mask[1] = 1'b1;
    @(posedge clk); #3;
    check("spurious_err", 32'(err), 1);
    check("spurious_no_mask", 32'(mask_valid), 0);
    for (int n = 0; n < 4; n++) lat[n] = 3;
    run_frame(80, 1'b0);

    // Asynchronous reset mid-frame, with masks still returning afterwards.
    for (int n = 0; n < 4; n++) lat[n] = 6;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0; data_valid = 1'b1;
    repeat (5) begin
      data = DW'($urandom);
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    data_valid = 1'b0;
    exp_q.delete();
    #1 check_reset("mid_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #3 check("late_mask_err", 32'(err), 1);
    for (int n = 0; n < 4; n++) lat[n] = $urandom_range(4, 1);
    run_frame(90, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
